regfile_param: RTL
==================

# regfile_param

Parametrised, resettable register file for the rv32i core. It generalises the fixed 32 x 32-bit file in four ways:
- configurable data width and depth;
- a synchronous hardware clear sequence that zeroes every entry after reset, with a `ready` status output;
- optional write-to-read bypass;
- optional registered (1-cycle) read ports.

It sits between decode (read addresses) and writeback (write port). The same body serves the single-cycle core (`REG_READ=0`) and a future pipelined core (`REG_READ=1`).

## Interface
Parameters:
- `DATA_WIDTH`, default 32: bits per register.
- `ADDR_WIDTH`, default 5: address width. `NUM_REGS = 2**ADDR_WIDTH`.
- `ZERO_REG`, default 1: when 1, entry 0 is hardwired zero (rv32i x0). When 0, entry 0 is an ordinary register.
- `BYPASS`, default 1: when 1, same-cycle write data is forwarded to matching read ports.
- `REG_READ`, default 0: 0 gives combinational reads. 1 gives reads registered on `clk` (latency 1).

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: active-high write enable.
- `wr_reg`, input, `ADDR_WIDTH`: write address.
- `wr_data`, input, `DATA_WIDTH`: write data.
- `rd_reg_1`, input, `ADDR_WIDTH`: read address, port 1.
- `rd_reg_2`, input, `ADDR_WIDTH`: read address, port 2.
- `rd_data_1`, output, `DATA_WIDTH`: read data, port 1.
- `rd_data_2`, output, `DATA_WIDTH`: read data, port 2.
- `ready`, output, 1: high once the clear sequence is complete and the file accepts writes.

## Operation
FSM with two states, INIT and READY.

INIT:
- Entered on any rising edge with `rst`=1, from either state. That edge sets the clear index `clr_idx` to 0.
- Each rising edge with `rst`=0 writes 0 into `mem[clr_idx]` and increments `clr_idx`.
- On the edge that clears `NUM_REGS-1`, the FSM moves to READY. `clr_idx` must not wrap back into INIT.
- User writes (`wr_en`) are ignored in INIT.
- All read data is forced to 0 in INIT, regardless of address or stale contents.
- `ready`=0.

READY:
- `ready`=1.
- A write updates `mem[wr_reg]` at the edge when `wr_en`=1 and the write is not suppressed.
- A write is suppressed when `ZERO_REG`=1 and `wr_reg`=0.

Read value for port n (`rdv_n`) in READY:
- If `ZERO_REG`=1 and `rd_reg_n`=0: 0.
- Otherwise, if `BYPASS`=1, `wr_en`=1, `wr_reg`=`rd_reg_n`, and the write is not suppressed: `wr_data`.
- Otherwise: `mem[rd_reg_n]`.

Output mapping:
- `REG_READ`=0: `rd_data_n` = `rdv_n`, combinational.
- `REG_READ`=1: `rd_data_n` is registered from `rdv_n` at each edge. It is loaded with 0 on a `rst` edge and on every INIT edge.

Simultaneous and boundary events:
- Both read ports may address the same register, and may match the write address, in the same cycle. Both see the same value.
- With `BYPASS`=0, a read of the register being written returns the old value during that cycle.
- Reset in mid-clear restarts the sequence at index 0. Reset during READY discards all contents: every entry reads 0 after the re-clear.
- `DATA_WIDTH` and `ADDR_WIDTH` may be any value ≥1. No arithmetic is performed on data; `clr_idx` is `ADDR_WIDTH` bits.

Assertions (simulation only):
- Read data from address 0 is 0 when `ZERO_REG`=1.
- `ready` never falls except on a `rst` edge.
- In INIT, `rd_data_1` and `rd_data_2` are 0.

## Timing
- Reset values: `ready`=0. `rd_data_1`/`rd_data_2` read 0: forced in INIT, or registered 0 when `REG_READ`=1.
- Clear latency: `ready` rises after exactly `NUM_REGS` rising edges with `rst`=0 following the last `rst` edge. For the default this is 32 edges.
- Write latency: the value is stored at the edge. It is visible on an unbypassed read in the following cycle.
- Read latency: 0 cycles with `REG_READ`=0. 1 cycle with `REG_READ`=1, with the bypass decision taken in the address cycle.
- No internal combinational path from `rst` to outputs. The only combinational input-to-output paths are read address and write data/address to `rd_data`, and only when `REG_READ`=0.

## Test plan
- **Reset/clear:** default parameters; hold `rst` for 3 cycles, then release. Drive `wr_en`=1, `wr_reg`=5, `wr_data`=0xDEADBEEF throughout. Required: `ready`=0 for 32 edges, then 1. x5 reads 0 (the INIT write is ignored). All 32 entries read 0.
- **Write/read and bypass:** write x7=0x12345678 with `rd_reg_1`=7 in the same cycle. `BYPASS`=1 gives 0x12345678 in that cycle. `BYPASS`=0 gives 0 in that cycle and 0x12345678 in the next.
- **Zero register:** write x0=0xFFFFFFFF with both read ports at 0. Required: `rd_data`=0 in that cycle and the next. With `ZERO_REG`=0, x0 reads 0xFFFFFFFF in the next cycle.
- **Registered reads:** `REG_READ`=1; write x3=0xA5A5A5A5, then read x3. Required: data appears one edge after the address is presented. A same-cycle bypass also appears one edge later.
- **Reset mid-clear and mid-operation:** assert `rst` for 1 cycle at clear index 10. Required: `ready` rises 32 edges after release. In READY, fill x1–x31 with nonzero values, pulse `rst`, wait for `ready`. Required: all entries read 0.
- **Non-default size:** `DATA_WIDTH`=16, `ADDR_WIDTH`=3. Required: `ready` after 8 edges. Write x7=0xBEEF and read back 0xBEEF on both ports.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with a hardware clear
// sequence, optional hardwired x0, write bypass and registered reads.
// Ports: clk, rst (sync, active high); wr_en/wr_reg/wr_data write port;
// rd_reg_1/rd_reg_2 -> rd_data_1/rd_data_2; ready = clear complete.
module regfile_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1,
   parameter bit REG_READ   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_reg,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_reg_1,
   input  logic [ADDR_WIDTH-1:0] rd_reg_2,
   output logic [DATA_WIDTH-1:0] rd_data_1,
   output logic [DATA_WIDTH-1:0] rd_data_2,
   output logic                  ready
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic                  wr_ok;
   logic [ADDR_WIDTH-1:0] rd_addr [2];
   logic [DATA_WIDTH-1:0] rd_d [2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Clear walks every index once; the last index hands over to
   // READY and holds the counter so it cannot wrap back.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      unique case (state_q)
         INIT: begin
            if (&clr_idx_q) begin
               state_d = READY;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   assign wr_ok = (state_q == READY) && wr_en &&
                  !(ZERO_REG && (wr_reg == '0));

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem_q[clr_idx_q] <= '0;
         end else if (wr_ok) begin
            mem_q[wr_reg] <= wr_data;
         end
      end
   end

   assign rd_addr[0] = rd_reg_1;
   assign rd_addr[1] = rd_reg_2;

   // Read value per port; forced to zero until the clear is done.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rd_d[i] = '0;
         if (state_q == READY) begin
            if (ZERO_REG && (rd_addr[i] == '0)) begin
               rd_d[i] = '0;
            end else if (BYPASS && wr_ok &&
                         (wr_reg == rd_addr[i])) begin
               rd_d[i] = wr_data;
            end else begin
               rd_d[i] = mem_q[rd_addr[i]];
            end
         end
      end
   end

   generate
      if (REG_READ) begin : g_rr
         logic [DATA_WIDTH-1:0] rd_q [2];

         always_ff @(posedge clk) begin
            if (rst || (state_q == INIT)) begin
               rd_q[0] <= '0;
               rd_q[1] <= '0;
            end else begin
               rd_q[0] <= rd_d[0];
               rd_q[1] <= rd_d[1];
            end
         end

         assign rd_data_1 = rd_q[0];
         assign rd_data_2 = rd_q[1];
      end else begin : g_comb
         assign rd_data_1 = rd_d[0];
         assign rd_data_2 = rd_d[1];
      end
   endgenerate

   assign ready = (state_q == READY);

`ifndef SYNTHESIS
   a_ready_fall : assert property (
      @(posedge clk) $fell(ready) |-> $past(rst));

   a_init_zero : assert property (
      @(posedge clk) (state_q == INIT) |->
         ((rd_data_1 == '0) && (rd_data_2 == '0)));

   generate
      if (ZERO_REG && !REG_READ) begin : g_a_zc
         a_x0_1 : assert property (
            @(posedge clk) (rd_reg_1 == '0) |-> (rd_data_1 == '0));
         a_x0_2 : assert property (
            @(posedge clk) (rd_reg_2 == '0) |-> (rd_data_2 == '0));
      end else if (ZERO_REG) begin : g_a_zr
         a_x0_1 : assert property (
            @(posedge clk) ($past(rd_reg_1) == '0) |->
               (rd_data_1 == '0));
         a_x0_2 : assert property (
            @(posedge clk) ($past(rd_reg_2) == '0) |->
               (rd_data_2 == '0));
      end
   endgenerate
`endif

endmodule
